dead_time_bridge: RTL

- Parametrised dead-time generator for N half-bridge legs, fed by the SVM_2_level modulator.
- Each leg turns one logical PWM command into a complementary high/low gate pair.
- Both gates are held off for a run-time programmable number of clocks on every transition, rising and falling.
- Adds per-leg enable/kill, aborts short pulses cleanly and flags swallowed pulses.

---
 rtl/dead_time_bridge.sv | 137 +++++++++++++
 1 files changed

// File: rtl/dead_time_bridge.sv
`default_nettype none
// ============================================================================
// Module      : dead_time_bridge
// Description : N-leg dead-time generator. Each leg turns a PWM command into
//               a complementary high/low gate pair separated by a dead time.
// Revision    : 1.0 - initial release
// ============================================================================
module dead_time_bridge #(
    parameter int N_CH   = 3,
    parameter int CNT_W  = 11,
    parameter int DT_MIN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] dt_cycles,
    input  logic [N_CH-1:0]  en,
    input  logic [N_CH-1:0]  pwm_in,
    output logic [N_CH-1:0]  gate_hi,
    output logic [N_CH-1:0]  gate_lo,
    output logic [N_CH-1:0]  swallow
);

    // A floor of zero would latch a zero interval that the counter never reaches.
    localparam int               c_DT_FLOOR = (DT_MIN < 1) ? 1 : DT_MIN;
    localparam logic [CNT_W-1:0] c_DT_MIN   = CNT_W'(c_DT_FLOOR);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [2:0] c_ST_OFF  = 3'd0;
    localparam logic [2:0] c_ST_DT_R = 3'd1;
    localparam logic [2:0] c_ST_HI   = 3'd2;
    localparam logic [2:0] c_ST_DT_F = 3'd3;
    localparam logic [2:0] c_ST_LO   = 3'd4;

    logic [CNT_W-1:0] w_dt_eff;

    assign w_dt_eff = (dt_cycles < c_DT_MIN) ? c_DT_MIN : dt_cycles;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_leg
            logic [2:0]       r_state;
            logic [2:0]       w_nxt;
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] r_lat;
            logic             r_hi;
            logic             r_lo;
            logic             r_swallow;
            logic             w_abort;
            logic             w_expired;
            logic             w_cur_dead;
            logic             w_nxt_dead;
            logic             w_enter_dead;

            assign w_expired  = (r_cnt == r_lat);
            assign w_cur_dead = (r_state == c_ST_DT_R) || (r_state == c_ST_DT_F);
            assign w_nxt_dead = (w_nxt == c_ST_DT_R) || (w_nxt == c_ST_DT_F);
            // Any change of state into a dead state, aborts included, restarts the interval.
            assign w_enter_dead = w_nxt_dead && (w_nxt != r_state);

            always_comb begin
                w_nxt   = r_state;
                w_abort = 1'b0;
                if (!en[gi]) begin
                    w_nxt = c_ST_OFF;
                end else begin
                    case (r_state)
                        c_ST_OFF: begin
                            w_nxt = pwm_in[gi] ? c_ST_DT_R : c_ST_DT_F;
                        end
                        c_ST_DT_R: begin
                            if (!pwm_in[gi]) begin
                                w_nxt   = c_ST_DT_F;
                                w_abort = 1'b1;
                            end else if (w_expired) begin
                                w_nxt = c_ST_HI;
                            end
                        end
                        c_ST_HI: begin
                            if (!pwm_in[gi]) begin
                                w_nxt = c_ST_DT_F;
                            end
                        end
                        c_ST_DT_F: begin
                            if (pwm_in[gi]) begin
                                w_nxt   = c_ST_DT_R;
                                w_abort = 1'b1;
                            end else if (w_expired) begin
                                w_nxt = c_ST_LO;
                            end
                        end
                        c_ST_LO: begin
                            if (pwm_in[gi]) begin
                                w_nxt = c_ST_DT_R;
                            end
                        end
                        default: begin
                            w_nxt = c_ST_OFF;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state   <= c_ST_OFF;
                    r_cnt     <= '0;
                    r_lat     <= '0;
                    r_hi      <= 1'b0;
                    r_lo      <= 1'b0;
                    r_swallow <= 1'b0;
                end else begin
                    r_state <= w_nxt;
                    r_hi    <= (w_nxt == c_ST_HI);
                    r_lo    <= (w_nxt == c_ST_LO);
                    if (w_enter_dead) begin
                        r_lat <= w_dt_eff;
                        r_cnt <= c_CNT_ONE;
                    end else if (w_cur_dead && w_nxt_dead) begin
                        if (r_cnt < r_lat) begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                    if (w_abort) begin
                        r_swallow <= 1'b1;
                    end
                end
            end

            assign gate_hi[gi] = r_hi;
            assign gate_lo[gi] = r_lo;
            assign swallow[gi] = r_swallow;
        end
    endgenerate

endmodule
`default_nettype wire
